// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Packet-locked round-robin arbiter that shares one UART
//             transmitter byte port among NUM_REQ requesters, with an idle
//             timeout that reclaims the port from a stalled owner.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_pulse
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // A zero timeout still needs a legal (unused) counter width.
    localparam int c_CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] c_ONEHOT0   = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [c_IDX_W-1:0] c_PTR_RESET = c_IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t               r_state, w_next_state;
    logic [NUM_REQ-1:0]   r_grant, w_next_grant;
    logic [c_IDX_W-1:0]   r_idx, w_next_idx;
    logic [c_IDX_W-1:0]   r_ptr, w_next_ptr;
    logic [c_CNT_W-1:0]   r_cnt, w_next_cnt;
    logic                 r_timeout_pulse, w_next_tpulse;

    logic                 w_found;
    logic [c_IDX_W-1:0]   w_pick;
    logic [c_IDX_W-1:0]   w_cand;
    logic                 w_owner_valid;
    logic                 w_xfer;
    logic                 w_timeout_hit;

    assign w_owner_valid = req_valid[r_idx];
    assign w_xfer        = (r_state == S_LOCKED) && w_owner_valid && tx_ready;
    assign w_timeout_hit = (IDLE_TIMEOUT > 0) && !w_owner_valid && (r_cnt == c_CNT_LAST);

    // Round-robin search: first valid requester after the last owner, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = c_IDX_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Next-state logic: lock on grant, release on last byte or idle timeout.
    always_comb begin
        w_next_state  = r_state;
        w_next_grant  = r_grant;
        w_next_idx    = r_idx;
        w_next_ptr    = r_ptr;
        w_next_cnt    = r_cnt;
        w_next_tpulse = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_cnt = '0;
                if (w_found) begin
                    w_next_state = S_LOCKED;
                    w_next_grant = c_ONEHOT0 << w_pick;
                    w_next_idx   = w_pick;
                end
            end
            S_LOCKED: begin
                w_next_cnt = w_owner_valid ? '0 : r_cnt + 1'b1;
                // A last-byte transfer needs valid high, so it always beats the timeout.
                if (w_xfer && req_last[r_idx]) begin
                    w_next_state = S_IDLE;
                    w_next_grant = '0;
                    w_next_ptr   = r_idx;
                    w_next_cnt   = '0;
                end else if (w_timeout_hit) begin
                    w_next_state  = S_IDLE;
                    w_next_grant  = '0;
                    w_next_ptr    = r_idx;
                    w_next_cnt    = '0;
                    w_next_tpulse = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_grant = '0;
            end
        endcase
    end

    // State and arbitration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_grant         <= '0;
            r_idx           <= '0;
            r_ptr           <= c_PTR_RESET;
            r_cnt           <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_grant         <= w_next_grant;
            r_idx           <= w_next_idx;
            r_ptr           <= w_next_ptr;
            r_cnt           <= w_next_cnt;
            r_timeout_pulse <= w_next_tpulse;
        end
    end

    // Byte path: the owner is passed straight through to the transmitter.
    always_comb begin
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        req_ready = '0;
        if (r_state == S_LOCKED) begin
            tx_data          = req_data[{r_idx, 3'b000} +: 8];
            tx_valid         = w_owner_valid;
            req_ready[r_idx] = tx_ready;
        end
    end

    assign grant         = r_grant;
    assign busy          = (r_state == S_LOCKED);
    assign timeout_pulse = r_timeout_pulse;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed self-checking bench for uart_tx_arbiter
//             (NUM_REQ=4, IDLE_TIMEOUT=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic            clk;
    logic            reset;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [NR-1:0]   grant;
    logic            busy;
    logic            timeout_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;
    int n_bad;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .IDLE_TIMEOUT (16)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted bytes at each active edge.
    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) n_xfer <= n_xfer + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Step to 2 time units after the next active edge, then drive.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]        = v;
        req_data[i*8 +: 8]  = d;
        req_last[i]         = l;
    endtask

    initial begin
        reset     = 1'b1;
        req_data  = '0;
        req_valid = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        #3;
        check("rst_grant",   32'(grant),         32'h0);
        check("rst_busy",    32'(busy),          32'h0);
        check("rst_txvalid", 32'(tx_valid),      32'h0);
        check("rst_ready",   32'(req_ready),     32'h0);
        check("rst_tpulse",  32'(timeout_pulse), 32'h0);
        cyc(); cyc();
        reset = 1'b0;

        // ---- Test 1: req0 sends 41 42 43 ----
        cyc();
        set_req(0, 1'b1, 8'h41, 1'b0);
        #1;
        check("t1_idle_grant", 32'(grant), 32'h0);
        check("t1_idle_txv",   32'(tx_valid), 32'h0);
        cyc();
        #1;
        check("t1_grant",  32'(grant),     32'h1);
        check("t1_busy",   32'(busy),      32'h1);
        check("t1_b0",     32'(tx_data),   32'h41);
        check("t1_ready",  32'(req_ready), 32'h1);
        cyc();
        set_req(0, 1'b1, 8'h42, 1'b0);
        #1;
        check("t1_b1", 32'(tx_data), 32'h42);
        cyc();
        set_req(0, 1'b1, 8'h43, 1'b1);
        #1;
        check("t1_b2", 32'(tx_data), 32'h43);
        cyc();
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        check("t1_end_busy",  32'(busy),  32'h0);
        check("t1_end_grant", 32'(grant), 32'h0);

        // ---- Test 2: four single-byte packets, then req1 and req3 ----
        reset = 1'b1;
        #1;
        reset = 1'b0;
        cyc();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(8'hA0 + i), 1'b1);
        for (int k = 0; k < NR; k++) begin
            cyc();
            #1;
            check($sformatf("t2_grant%0d", k), 32'(grant),   32'(1 << k));
            check($sformatf("t2_data%0d", k),  32'(tx_data), 32'(8'hA0 + k));
            cyc();
            set_req(k, 1'b0, 8'h00, 1'b0);
            #1;
            check($sformatf("t2_gap%0d", k), 32'(grant), 32'h0);
        end
        set_req(1, 1'b1, 8'hA1, 1'b1);
        set_req(3, 1'b1, 8'hA3, 1'b1);
        cyc();
        #1;
        check("t2b_first", 32'(grant), 32'h2);
        cyc();
        set_req(1, 1'b0, 8'h00, 1'b0);
        cyc();
        #1;
        check("t2b_second", 32'(grant),   32'h8);
        check("t2b_data",   32'(tx_data), 32'hA3);
        cyc();
        set_req(3, 1'b0, 8'h00, 1'b0);

        // ---- Test 3: req0 4-byte packet with req2 waiting ----
        set_req(0, 1'b1, 8'h10, 1'b0);
        set_req(2, 1'b1, 8'hC2, 1'b1);
        #1;
        check("t3_idle", 32'(grant), 32'h0);
        cyc();
        for (int b = 0; b < 4; b++) begin
            if (b > 0) set_req(0, 1'b1, 8'(8'h10 + b), (b == 3));
            #1;
            check($sformatf("t3_lock%0d", b), 32'(grant),   32'h1);
            check($sformatf("t3_data%0d", b), 32'(tx_data), 32'(8'h10 + b));
            cyc();
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        check("t3_gap", 32'(grant), 32'h0);
        cyc();
        #1;
        check("t3_req2", 32'(grant),   32'h4);
        check("t3_c2",   32'(tx_data), 32'hC2);
        cyc();
        set_req(2, 1'b0, 8'h00, 1'b0);

        // ---- Test 4: idle timeout of 16 cycles ----
        set_req(1, 1'b1, 8'h55, 1'b0);
        set_req(2, 1'b1, 8'hD2, 1'b1);
        cyc();
        #1;
        check("t4_grant1", 32'(grant),   32'h2);
        check("t4_data",   32'(tx_data), 32'h55);
        cyc();
        set_req(1, 1'b0, 8'hEE, 1'b1);
        n_bad = 0;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) cyc();
            #1;
            if (busy !== 1'b1 || grant !== 4'h2 || timeout_pulse !== 1'b0) n_bad++;
        end
        check("t4_hold16", 32'(n_bad), 32'h0);
        cyc();
        #1;
        check("t4_rel_grant", 32'(grant),         32'h0);
        check("t4_pulse",     32'(timeout_pulse), 32'h1);
        check("t4_rel_busy",  32'(busy),          32'h0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        cyc();
        #1;
        check("t4_pulse_end", 32'(timeout_pulse), 32'h0);
        check("t4_req2",      32'(grant),         32'h4);
        cyc();
        set_req(2, 1'b0, 8'h00, 1'b0);

        // ---- Test 5: transmitter busy for 1085 cycles ----
        tx_ready = 1'b0;
        set_req(3, 1'b1, 8'h7E, 1'b1);
        cyc();
        #1;
        check("t5_grant", 32'(grant), 32'h8);
        n_xfer = 0;
        n_bad  = 0;
        for (int j = 0; j < 1085; j++) begin
            if (req_ready !== 4'h0 || tx_data !== 8'h7E || busy !== 1'b1 ||
                timeout_pulse !== 1'b0 || tx_valid !== 1'b1) n_bad++;
            cyc();
            #1;
        end
        check("t5_stall", 32'(n_bad), 32'h0);
        tx_ready = 1'b1;
        #1;
        check("t5_ready", 32'(req_ready), 32'h8);
        cyc();
        set_req(3, 1'b0, 8'h00, 1'b0);
        #1;
        check("t5_done", 32'(grant), 32'h0);
        cyc(); cyc();
        check("t5_xfers", 32'(n_xfer), 32'h1);

        // ---- Test 6: asynchronous reset mid-packet ----
        set_req(2, 1'b1, 8'h22, 1'b0);
        cyc();
        #1;
        check("t6_grant2", 32'(grant), 32'h4);
        cyc();
        set_req(2, 1'b1, 8'h23, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("t6_grant",  32'(grant),     32'h0);
        check("t6_busy",   32'(busy),      32'h0);
        check("t6_txv",    32'(tx_valid),  32'h0);
        check("t6_ready",  32'(req_ready), 32'h0);
        set_req(0, 1'b1, 8'h01, 1'b1);
        #1;
        reset = 1'b0;
        cyc();
        #1;
        check("t6_req0_first", 32'(grant), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
